// File: rtl/cv_ctrl_pkg.sv
// Shared constants for the ColecoVision controller port: keypad pin codes,
// MiSTer joystick bit positions, key indices and the PS/2 scan-code map.
package cv_ctrl_pkg;

  localparam logic [3:0] CODE_0      = 4'b0011;
  localparam logic [3:0] CODE_1      = 4'b1110;
  localparam logic [3:0] CODE_2      = 4'b1101;
  localparam logic [3:0] CODE_3      = 4'b0110;
  localparam logic [3:0] CODE_4      = 4'b0001;
  localparam logic [3:0] CODE_5      = 4'b1001;
  localparam logic [3:0] CODE_6      = 4'b0111;
  localparam logic [3:0] CODE_7      = 4'b1100;
  localparam logic [3:0] CODE_8      = 4'b1000;
  localparam logic [3:0] CODE_9      = 4'b1011;
  localparam logic [3:0] CODE_STAR   = 4'b1010;
  localparam logic [3:0] CODE_HASH   = 4'b0101;
  localparam logic [3:0] CODE_PURPLE = 4'b0100;
  localparam logic [3:0] CODE_BLUE   = 4'b0010;
  localparam logic [3:0] CODE_NONE   = 4'b1111;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_ARM    = 5;
  localparam int JOY_STAR   = 6;
  localparam int JOY_HASH   = 7;
  localparam int JOY_0      = 8;
  localparam int JOY_1      = 9;
  localparam int JOY_2      = 10;
  localparam int JOY_3      = 11;
  localparam int JOY_PURPLE = 12;
  localparam int JOY_BLUE   = 13;

  localparam int NUM_PAD  = 14;
  localparam int NUM_KEYS = 20;

  // Keypad keys occupy 0..13 in descending encoder priority.
  typedef enum logic [4:0] {
    KEY_0 = 5'd0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
    KEY_STAR, KEY_HASH, KEY_PURPLE, KEY_BLUE,
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_FIRE, KEY_ARM
  } key_e;

  function automatic logic [3:0] pad_code(input logic [3:0] idx);
    logic [3:0] c;
    case (idx)
      4'd0:    c = CODE_0;
      4'd1:    c = CODE_1;
      4'd2:    c = CODE_2;
      4'd3:    c = CODE_3;
      4'd4:    c = CODE_4;
      4'd5:    c = CODE_5;
      4'd6:    c = CODE_6;
      4'd7:    c = CODE_7;
      4'd8:    c = CODE_8;
      4'd9:    c = CODE_9;
      4'd10:   c = CODE_STAR;
      4'd11:   c = CODE_HASH;
      4'd12:   c = CODE_PURPLE;
      4'd13:   c = CODE_BLUE;
      default: c = CODE_NONE;
    endcase
    return c;
  endfunction

  // Returns {valid, key index}; the extended flag only matters for 0x12.
  function automatic logic [5:0] map_scan(input logic ext, input logic [7:0] code);
    logic [5:0] r;
    case (code)
      8'h75:              r = {1'b1, KEY_UP};
      8'h72:              r = {1'b1, KEY_DOWN};
      8'h6B:              r = {1'b1, KEY_LEFT};
      8'h74:              r = {1'b1, KEY_RIGHT};
      8'h16:              r = {1'b1, KEY_1};
      8'h1E:              r = {1'b1, KEY_2};
      8'h26:              r = {1'b1, KEY_3};
      8'h15, 8'h25:       r = {1'b1, KEY_4};
      8'h1D, 8'h2E:       r = {1'b1, KEY_5};
      8'h24, 8'h36:       r = {1'b1, KEY_6};
      8'h1C, 8'h3D:       r = {1'b1, KEY_7};
      8'h1B, 8'h3E:       r = {1'b1, KEY_8};
      8'h23, 8'h46:       r = {1'b1, KEY_9};
      8'h22, 8'h45:       r = {1'b1, KEY_0};
      8'h1A:              r = {1'b1, KEY_STAR};
      8'h21:              r = {1'b1, KEY_HASH};
      8'h1F, 8'h27:       r = {1'b1, KEY_PURPLE};
      8'h11:              r = {1'b1, KEY_BLUE};
      8'h12:              r = ext ? 6'd0 : {1'b1, KEY_ARM};
      8'h59:              r = {1'b1, KEY_ARM};
      8'h14:              r = {1'b1, KEY_FIRE};
      default:            r = 6'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cv_keypad_enc.sv
// Priority encoder from the 14 keypad key states to the 4-bit keypad pin code;
// lower index wins, no key pressed gives all pins high.
module cv_keypad_enc
  import cv_ctrl_pkg::*;
(
  input  logic [13:0] keys,
  output logic [3:0]  code
);

  always_comb begin
    code = CODE_NONE;
    for (int i = 13; i >= 0; i--) begin
      if (keys[i]) code = pad_code(4'(i));
    end
  end

endmodule

// File: rtl/cv_ctrl_port.sv
// ColecoVision controller front-end: PS/2 key decode with keypad hold
// stretching, merged with MiSTer joysticks and driven onto the select-muxed pins.
module cv_ctrl_port
  import cv_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES = 42954,
  parameter int HOLD_TICKS  = 20
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [10:0] ps2_key_i,
  input  logic [15:0] joy0_i,
  input  logic [15:0] joy1_i,
  input  logic [1:0]  ctrl_p5_i,
  input  logic [1:0]  ctrl_p8_i,
  output logic [1:0]  ctrl_p1_o,
  output logic [1:0]  ctrl_p2_o,
  output logic [1:0]  ctrl_p3_o,
  output logic [1:0]  ctrl_p4_o,
  output logic [1:0]  ctrl_p6_o
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]       presc;
  logic                tick;
  logic                prev_tgl;
  logic                primed;
  logic                key_event;
  logic [5:0]          map;
  logic [4:0]          map_idx;
  logic                map_valid;
  logic [NUM_KEYS-1:0] key_reg;
  logic [7:0]          hold_cnt [NUM_PAD];
  logic [NUM_PAD-1:0]  eff_pad;
  logic [13:0]         pad_keys [2];
  logic [3:0]          code [2];
  logic [3:0]          dir [2];
  logic [1:0]          fire;
  logic [1:0]          arm;
  logic [3:0]          term [2];
  logic [1:0]          p6_term;

  assign tick      = (presc == PW'(TICK_CYCLES - 1));
  assign key_event = primed && (ps2_key_i[10] != prev_tgl);
  assign map       = map_scan(ps2_key_i[8], ps2_key_i[7:0]);
  assign map_valid = map[5];
  assign map_idx   = map[4:0];

  // The first clock after reset only samples the toggle so a stale level never decodes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc    <= '0;
      prev_tgl <= 1'b0;
      primed   <= 1'b0;
      key_reg  <= '0;
      for (int k = 0; k < NUM_PAD; k++) hold_cnt[k] <= 8'd0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      prev_tgl <= ps2_key_i[10];
      primed   <= 1'b1;
      if (key_event && map_valid) key_reg[map_idx] <= ps2_key_i[9];
      for (int k = 0; k < NUM_PAD; k++) begin
        if (key_event && map_valid && ps2_key_i[9] && (map_idx == 5'(k)))
          hold_cnt[k] <= 8'(HOLD_TICKS);
        else if (!key_reg[k] && tick && (hold_cnt[k] != 8'd0))
          hold_cnt[k] <= hold_cnt[k] - 8'd1;
      end
    end
  end

  always_comb begin
    eff_pad = '0;
    for (int k = 0; k < NUM_PAD; k++) eff_pad[k] = key_reg[k] | (hold_cnt[k] != 8'd0);
  end

  assign pad_keys[0] = eff_pad | {joy0_i[JOY_BLUE], joy0_i[JOY_PURPLE], joy0_i[JOY_HASH],
                                  joy0_i[JOY_STAR], 6'b0, joy0_i[JOY_3], joy0_i[JOY_2],
                                  joy0_i[JOY_1], joy0_i[JOY_0]};
  assign pad_keys[1] = {joy1_i[JOY_BLUE], joy1_i[JOY_PURPLE], joy1_i[JOY_HASH],
                        joy1_i[JOY_STAR], 6'b0, joy1_i[JOY_3], joy1_i[JOY_2],
                        joy1_i[JOY_1], joy1_i[JOY_0]};

  assign dir[0] = {key_reg[KEY_UP], key_reg[KEY_DOWN], key_reg[KEY_LEFT], key_reg[KEY_RIGHT]}
                | {joy0_i[JOY_UP], joy0_i[JOY_DOWN], joy0_i[JOY_LEFT], joy0_i[JOY_RIGHT]};
  assign dir[1] = {joy1_i[JOY_UP], joy1_i[JOY_DOWN], joy1_i[JOY_LEFT], joy1_i[JOY_RIGHT]};
  assign fire   = {joy1_i[JOY_FIRE], key_reg[KEY_FIRE] | joy0_i[JOY_FIRE]};
  assign arm    = {joy1_i[JOY_ARM],  key_reg[KEY_ARM]  | joy0_i[JOY_ARM]};

  for (genvar i = 0; i < 2; i++) begin : g_player
    cv_keypad_enc u_enc (
      .keys (pad_keys[i]),
      .code (code[i])
    );
    // With both selects low the open-collector pins wire-AND the two terms.
    assign term[i]    = (ctrl_p5_i[i] ? CODE_NONE : code[i])
                      & (ctrl_p8_i[i] ? CODE_NONE : ~dir[i]);
    assign p6_term[i] = (ctrl_p5_i[i] | ~arm[i]) & (ctrl_p8_i[i] | ~fire[i]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_p1_o <= 2'b11;
      ctrl_p2_o <= 2'b11;
      ctrl_p3_o <= 2'b11;
      ctrl_p4_o <= 2'b11;
      ctrl_p6_o <= 2'b11;
    end else begin
      ctrl_p1_o <= {term[1][3], term[0][3]};
      ctrl_p2_o <= {term[1][2], term[0][2]};
      ctrl_p3_o <= {term[1][1], term[0][1]};
      ctrl_p4_o <= {term[1][0], term[0][0]};
      ctrl_p6_o <= p6_term;
    end
  end

endmodule

// File: tb/tb_cv_ctrl_port.sv
// Directed bench for cv_ctrl_port with a short hold tick so stretching is observable.
module tb_cv_ctrl_port;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy0;
  logic [15:0] joy1;
  logic [1:0]  p5;
  logic [1:0]  p8;
  logic [1:0]  p1, p2, p3, p4, p6;

  int total = 0;
  int bad   = 0;

  cv_ctrl_port #(.TICK_CYCLES(4), .HOLD_TICKS(2)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .ps2_key_i (ps2_key),
    .joy0_i    (joy0),
    .joy1_i    (joy1),
    .ctrl_p5_i (p5),
    .ctrl_p8_i (p8),
    .ctrl_p1_o (p1),
    .ctrl_p2_o (p2),
    .ctrl_p3_o (p3),
    .ctrl_p4_o (p4),
    .ctrl_p6_o (p6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 event: flip the toggle and present the code, then let it settle.
  task automatic applyStimulus(input logic ext, input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    waitClocks(3);
  endtask

  function automatic logic [3:0] pins(input int i);
    return {p1[i], p2[i], p3[i], p4[i]};
  endfunction

  initial begin
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    joy0 = '0;
    joy1 = '0;
    p5 = 2'b00;
    p8 = 2'b11;
    #12;
    checkOutput("reset_all", {22'd0, p1, p2, p3, p4, p6}, {22'd0, 10'h3FF});
    #3 reset_n = 1'b1;
    waitClocks(3);
    checkOutput("no_decode_at_release", {28'd0, pins(0)}, 32'hF);

    applyStimulus(1'b0, 8'h16, 1'b1);
    checkOutput("key1", {28'd0, pins(0)}, 32'b1110);
    checkOutput("p2_idle", {28'd0, pins(1)}, 32'hF);
    checkOutput("p6_idle", {30'd0, p6}, 32'b11);

    applyStimulus(1'b0, 8'h22, 1'b1);
    checkOutput("key0_wins", {28'd0, pins(0)}, 32'b0011);
    applyStimulus(1'b0, 8'h22, 1'b0);
    checkOutput("key0_stretched", {28'd0, pins(0)}, 32'b0011);
    waitClocks(12);
    checkOutput("key0_expired", {28'd0, pins(0)}, 32'b1110);

    joy0 = 16'h0018;
    p8 = 2'b10;
    p5 = 2'b11;
    waitClocks(2);
    checkOutput("joy_up", {28'd0, pins(0)}, 32'b0111);
    checkOutput("joy_fire", {31'd0, p6[0]}, 32'd0);
    p5 = 2'b10;
    waitClocks(2);
    checkOutput("wired_and", {28'd0, pins(0)}, 32'b0110);
    checkOutput("p2_unselected", {28'd0, pins(1)}, 32'hF);

    joy0 = '0;
    p8 = 2'b11;
    p5 = 2'b00;
    applyStimulus(1'b0, 8'h16, 1'b0);
    waitClocks(12);
    checkOutput("key1_released", {28'd0, pins(0)}, 32'hF);

    p8 = 2'b10;
    p5 = 2'b10;
    applyStimulus(1'b0, 8'h5A, 1'b1);
    checkOutput("unmapped_ignored", {28'd0, pins(0)}, 32'hF);
    p5 = 2'b11;
    applyStimulus(1'b1, 8'h75, 1'b1);
    checkOutput("ext_up", {28'd0, pins(0)}, 32'b0111);
    applyStimulus(1'b1, 8'h75, 1'b0);
    checkOutput("up_released", {28'd0, pins(0)}, 32'hF);

    p5 = 2'b10;
    p8 = 2'b11;
    applyStimulus(1'b0, 8'h1A, 1'b1);
    applyStimulus(1'b0, 8'h21, 1'b1);
    checkOutput("star_over_hash", {28'd0, pins(0)}, 32'b1010);
    applyStimulus(1'b0, 8'h1A, 1'b0);
    applyStimulus(1'b0, 8'h21, 1'b0);
    waitClocks(12);
    applyStimulus(1'b0, 8'h12, 1'b1);
    checkOutput("arm_key", {31'd0, p6[0]}, 32'd0);
    applyStimulus(1'b0, 8'h12, 1'b0);

    joy1 = 16'h0220;
    p5 = 2'b01;
    waitClocks(2);
    checkOutput("p2_key1", {28'd0, pins(1)}, 32'b1110);
    checkOutput("p2_arm", {30'd0, p6}, 32'b01);
    joy1 = 16'h0002;
    p5 = 2'b11;
    p8 = 2'b01;
    waitClocks(2);
    checkOutput("p2_left", {28'd0, pins(1)}, 32'b1101);
    joy1 = '0;
    p8 = 2'b11;

    p5 = 2'b00;
    applyStimulus(1'b0, 8'h22, 1'b1);
    applyStimulus(1'b0, 8'h22, 1'b0);
    checkOutput("hold_before_reset", {28'd0, pins(0)}, 32'b0011);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset", {22'd0, p1, p2, p3, p4, p6}, {22'd0, 10'h3FF});
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
    #10 reset_n = 1'b1;
    waitClocks(3);
    checkOutput("cleared_after_reset", {28'd0, pins(0)}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
